// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: bus/mask typedefs, FSM states and a
// lane-mask expansion helper.
package data_mem_responder_pkg;

    typedef logic [31:0] dataBus_t;
    typedef logic [3:0]  byteMask_t;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_WAIT,
        MR_RESP
    } memRespState_t;

    // Widen a 4-bit byte-lane mask to a 32-bit bit mask.
    function automatic dataBus_t lane_expand(input byteMask_t mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with independent write enables per byte lane and an asynchronous
// read port sharing the write address.
module byte_lane_ram
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  byteMask_t             we,
    input  dataBus_t              wdata,
    output dataBus_t              rdata
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    dataBus_t mem [Depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Far end of the core's data-memory interface: byte-writable word array answered through a
// ready handshake after WAIT_CYCLES stall cycles, with range and rd/wr-conflict error pulses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_data_rd_en_ma,
    input  logic      i_data_wr_en_ma,
    input  dataBus_t  i_data_addr,
    input  dataBus_t  i_data_wr,
    input  byteMask_t i_data_rd_en_ctrl,
    output logic      o_data_ready,
    output dataBus_t  o_data_rd,
    output logic      o_err
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    memRespState_t state_q;
    logic [CntW-1:0] cnt_q;
    logic       lat_rd_q, lat_wr_q;
    dataBus_t   lat_addr_q, lat_data_q;
    byteMask_t  lat_mask_q;

    logic       req;
    logic       in_resp, acc_rd, acc_wr, active, out_of_range;
    dataBus_t   acc_addr, acc_data, ram_rdata;
    byteMask_t  acc_mask, ram_we;
    logic       unused_addr_lsb;

    assign req = i_data_rd_en_ma | i_data_wr_en_ma;

    // With no wait states the live request is the response; otherwise the latched copy is.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_rd   = i_data_rd_en_ma;
            acc_wr   = i_data_wr_en_ma;
            acc_addr = i_data_addr;
            acc_data = i_data_wr;
            acc_mask = i_data_rd_en_ctrl;
            in_resp  = req;
        end else begin
            acc_rd   = lat_rd_q;
            acc_wr   = lat_wr_q;
            acc_addr = lat_addr_q;
            acc_data = lat_data_q;
            acc_mask = lat_mask_q;
            in_resp  = (state_q == MR_RESP);
        end
    end

    assign unused_addr_lsb = ^acc_addr[1:0];
    assign out_of_range    = (acc_addr[31:ADDR_WIDTH+2] != '0);
    assign active          = in_resp && (acc_mask != '0);

    assign ram_we    = (active && acc_wr && !out_of_range) ? acc_mask : '0;
    assign o_err     = active && (out_of_range || (acc_rd && acc_wr));
    assign o_data_rd = (active && acc_rd && !acc_wr && !out_of_range)
                     ? (ram_rdata & lane_expand(acc_mask)) : '0;

    always_comb begin
        o_data_ready = 1'b1;
        if (WAIT_CYCLES != 0) begin
            unique case (state_q)
                MR_IDLE: o_data_ready = !req;
                MR_WAIT: o_data_ready = 1'b0;
                MR_RESP: o_data_ready = 1'b1;
                default: o_data_ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MR_IDLE;
            cnt_q      <= '0;
            lat_rd_q   <= 1'b0;
            lat_wr_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_mask_q <= '0;
        end else begin
            unique case (state_q)
                MR_IDLE: begin
                    if (WAIT_CYCLES != 0 && req) begin
                        lat_rd_q   <= i_data_rd_en_ma;
                        lat_wr_q   <= i_data_wr_en_ma;
                        lat_addr_q <= i_data_addr;
                        lat_data_q <= i_data_wr;
                        lat_mask_q <= i_data_rd_en_ctrl;
                        cnt_q      <= CntW'(WAIT_CYCLES - 1);
                        state_q    <= (WAIT_CYCLES > 1) ? MR_WAIT : MR_RESP;
                    end
                end
                MR_WAIT: begin
                    // Leave when this decrement reaches zero.
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= MR_RESP;
                    end
                end
                MR_RESP: begin
                    lat_rd_q <= 1'b0;
                    lat_wr_q <= 1'b0;
                    state_q  <= MR_IDLE;
                end
                default: state_q <= MR_IDLE;
            endcase
        end
    end

    byte_lane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .addr (acc_addr[ADDR_WIDTH+1:2]),
        .we   (ram_we),
        .wdata(acc_data),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (0, 2 and 3 wait states) driven
// in turn with directed and random accesses against a word-array reference model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int NDut = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en [NDut];
    logic        wr_en [NDut];
    logic [31:0] addr  [NDut];
    logic [31:0] wdata [NDut];
    logic [3:0]  mask  [NDut];
    logic        ready [NDut];
    logic [31:0] rdata [NDut];
    logic        err   [NDut];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        localparam int unsigned Wc = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        data_mem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_CYCLES(Wc)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .i_data_rd_en_ma  (rd_en[g]),
            .i_data_wr_en_ma  (wr_en[g]),
            .i_data_addr      (addr[g]),
            .i_data_wr        (wdata[g]),
            .i_data_rd_en_ctrl(mask[g]),
            .o_data_ready     (ready[g]),
            .o_data_rd        (rdata[g]),
            .o_err            (err[g])
        );
    end

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [NDut][1024];
    int          sel;
    bit          mon_en;
    int          n_pass;
    int          n_checks;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (dut %0d, t=%0t)",
                      name, act, exp, sel, $time);
    endtask

    // Reference: what the access should return, and its effect on the word array.
    task automatic model_access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m, output exp_t e);
        int w;
        bit oor;
        w     = int'(a[11:2]);
        oor   = (a[31:12] != 20'd0);
        e.rd  = 32'd0;
        e.err = 1'b0;
        if (m == 4'd0) return;
        if (oor || (rd && wr)) e.err = 1'b1;
        if (wr && !oor) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) model[k][w][8*i +: 8] = d[8*i +: 8];
        end
        if (rd && !wr && !oor) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) e.rd[8*i +: 8] = model[k][w][8*i +: 8];
        end
    endtask

    // Issue one access on dut k (called at posedge+1), hold it until ready.
    task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        int   cnt;
        model_access(k, rd, wr, a, d, m, e);
        exp_q.push_back(e);
        rd_en[k] = rd;
        wr_en[k] = wr;
        addr[k]  = a;
        wdata[k] = d;
        mask[k]  = m;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (ready[k]) break;
            if (cnt > 40) begin
                $display("FAIL ready_timeout: dut %0d never raised ready", k);
                break;
            end
            // Inputs after the latching edge must be ignored.
            if (cnt >= 2) begin
                addr[k]  = $urandom;
                wdata[k] = $urandom;
                mask[k]  = 4'($urandom);
            end
        end
        chk("latency", cnt, wait_of(k) + 1);
        @(posedge clk);
        #1;
        rd_en[k] = 1'b0;
        wr_en[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            if ((rd_en[sel] || wr_en[sel]) && ready[sel]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL resp_unexpected: response with empty scoreboard, dut %0d", sel);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rd", rdata[sel], e.rd);
                    chk("resp_err", {31'd0, err[sel]}, {31'd0, e.err});
                end
            end else begin
                chk("quiet_rd", rdata[sel], 32'd0);
                chk("quiet_err", {31'd0, err[sel]}, 32'd0);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op, idx;
        n_pass = 0;
        n_checks = 0;
        mon_en = 1'b0;
        sel = 0;
        for (int k = 0; k < NDut; k++) begin
            rd_en[k] = 1'b0;
            wr_en[k] = 1'b0;
            addr[k]  = 32'd0;
            wdata[k] = 32'd0;
            mask[k]  = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDut; k++) begin
            chk("reset_ready", {31'd0, ready[k]}, 32'd1);
            chk("reset_rd", rdata[k], 32'd0);
            chk("reset_err", {31'd0, err[k]}, 32'd0);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int k = 0; k < NDut; k++) begin
            sel = k;
            for (int w = 0; w <= 16; w++)
                access(k, 1'b0, 1'b1, {20'd0, (w == 16) ? 10'd1023 : 10'(w), 2'b00}, $urandom, 4'hF);
            access(k, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
            access(k, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
            access(k, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1);
            access(k, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
            access(k, 1'b1, 1'b0, 32'h10, 32'd0, 4'h4);
            access(k, 1'b0, 1'b1, 32'h1000, 32'h55555555, 4'hF);
            access(k, 1'b1, 1'b0, 32'h1000, 32'd0, 4'hF);
            access(k, 1'b1, 1'b0, 32'h0, 32'd0, 4'hF);
            access(k, 1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF);
            access(k, 1'b1, 1'b0, 32'h14, 32'd0, 4'hF);
            access(k, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
            access(k, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
            access(k, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
            for (int n = 0; n < 150; n++) begin
                op  = $urandom_range(0, 9);
                idx = $urandom_range(0, 16);
                if ($urandom_range(0, 7) == 0)
                    a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
                else
                    a = {20'd0, (idx == 16) ? 10'd1023 : 10'(idx), 2'($urandom)};
                access(k, (op < 4) || (op >= 8), (op >= 4) && (op <= 8), a, $urandom,
                       4'($urandom));
                idle($urandom_range(0, 2));
            end
            idle(2);
        end

        // Reset while a write is stalled on the 3-wait instance: the write must be dropped.
        sel = 2;
        rd_en[2] = 1'b0;
        wr_en[2] = 1'b1;
        addr[2]  = 32'h18;
        wdata[2] = 32'hCAFEF00D;
        mask[2]  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wr_en[2] = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready[2]}, 32'd1);
        chk("rst_rd", rdata[2], 32'd0);
        chk("rst_err", {31'd0, err[2]}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(2, 1'b1, 1'b0, 32'h18, 32'd0, 4'hF);
        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
